// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file write port.
// The primary (in-order pipeline) writeback always wins. The secondary
// (long-latency) writebacks are queued in a small FIFO and drained when the
// primary source is idle. Each queued entry carries a live bit. A younger
// primary write to the same register clears that bit, so the stale entry is
// popped without writing the file.
// Optional feature macro: WB_PENDING_MASK_EN. It builds the pending_mask
// decode. When it is undefined, pending_mask is tied to zero.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          ctrl_reset,
  input  logic          p_valid,
  input  logic [4:0]    p_reg,
  input  logic [31:0]   p_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [4:0]    s_reg,
  input  logic [31:0]   s_data,
  output logic          ctrl_writeEnable,
  output logic [4:0]    ctrl_writeReg,
  output logic [31:0]   data_writeReg,
  output logic [AW:0]   fifo_count,
  output logic [31:0]   pending_mask
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // FIFO storage: register/data arrays are not reset; validity is tracked
  // by live_q and count_q.
  logic [4:0]       reg_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [DEPTH-1:0] live_d;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;

  // Cleared by reset and set on the first clock edge afterwards. Until then
  // nothing is written, so no write lands on the edge after reset release.
  logic armed_q;

  logic p_act;
  logic enq;
  logic pop;
  logic head_live;

  assign s_ready    = (count_q != FULL_COUNT);
  assign fifo_count = count_q;

  // A primary write to r0 is treated as no request at all.
  assign p_act = armed_q & p_valid & (p_reg != 5'd0);
  // Secondary writes to r0 are accepted and then dropped.
  assign enq = s_valid & s_ready & (s_reg != 5'd0);
  // The FIFO drains only when the primary source leaves the port free.
  // A dead head still consumes its cycle.
  assign pop = armed_q & ~p_act & (count_q != '0);
  assign head_live = live_q[rd_ptr_q];

  // Per-entry live bit next state. A fresh enqueue sets the bit, a pop
  // clears it, and a primary write to the entry's register kills it. The
  // enqueue slot is always unoccupied, so its stale reg_q must not kill the
  // new (younger) entry, which is why enqueue has priority.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
    assign live_d[gi] = (enq && wr_ptr_q == AW'(gi))           ? 1'b1 :
                        (pop && rd_ptr_q == AW'(gi))           ? 1'b0 :
                        (p_act && reg_q[gi] == p_reg)          ? 1'b0 :
                        live_q[gi];
  end

  // Occupancy next state. A simultaneous enqueue and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO payload write on enqueue.
  always_ff @(posedge clock) begin
    if (enq) begin
      reg_q[wr_ptr_q]  <= s_reg;
      data_q[wr_ptr_q] <= s_data;
    end
  end

  // FIFO control state: pointers wrap naturally at a power-of-two DEPTH.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      live_q  <= live_d;
      armed_q <= 1'b1;
    end
  end

  // Registered write port. Primary first, then a live FIFO head. Otherwise
  // enable drops and the address/data hold their last values.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else if (p_act) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= p_reg;
      data_writeReg    <= p_data;
    end else if (pop && head_live) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= reg_q[rd_ptr_q];
      data_writeReg    <= data_q[rd_ptr_q];
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

`ifdef WB_PENDING_MASK_EN
  logic [31:0] pending_mask_d;

  // Hazard mask: OR the one-hot of every live entry's register. Popped
  // entries have their live bit cleared, so empty slots never contribute.
  always_comb begin
    pending_mask_d = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask_d[reg_q[i]] = 1'b1;
    end
  end

  assign pending_mask = pending_mask_d;
`else
  assign pending_mask = 32'd0;
`endif

endmodule
